// File: rtl/decision_tree.sv
// Depth-3 binary decision-tree classifier over three unsigned features, one tree level per clock.
// Define DT_HOLD_Y_EN to keep y_o at the last result between OUT cycles (otherwise y_o is 0 outside OUT).
module decision_tree #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned T0     = 128,
   parameter int unsigned T1     = 64,
   parameter int unsigned T2     = 192,
   parameter int unsigned T3     = 64,
   parameter int unsigned T4     = 192,
   parameter int unsigned T5     = 64,
   parameter int unsigned T6     = 192,
   parameter int unsigned LEAF0  = 10,
   parameter int unsigned LEAF1  = 20,
   parameter int unsigned LEAF2  = 30,
   parameter int unsigned LEAF3  = 40,
   parameter int unsigned LEAF4  = 50,
   parameter int unsigned LEAF5  = 60,
   parameter int unsigned LEAF6  = 70,
   parameter int unsigned LEAF7  = 80
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start_i,
   input  logic [DATA_W-1:0] x1_i,
   input  logic [DATA_W-1:0] x2_i,
   input  logic [DATA_W-1:0] x3_i,
   output logic [DATA_W-1:0] y_o,
   output logic              y_valid_o
);

   typedef enum logic [2:0] {S_IDLE, S_L0, S_L1, S_L2, S_OUT} state_t;

   state_t            state, state_nxt;
   logic [3:0]        node, node_x2, child;
   logic [DATA_W-1:0] x1_lat, x2_lat, x3_lat, feat, y_lat;
   logic              cmp, load;

   function automatic logic [DATA_W-1:0] thr(input logic [3:0] n);
      case (n)
         4'd0:    return DATA_W'(T0);
         4'd1:    return DATA_W'(T1);
         4'd2:    return DATA_W'(T2);
         4'd3:    return DATA_W'(T3);
         4'd4:    return DATA_W'(T4);
         4'd5:    return DATA_W'(T5);
         4'd6:    return DATA_W'(T6);
         default: return '0;
      endcase
   endfunction

   // Leaves are tree nodes 7..14; anything else cannot reach OUT.
   function automatic logic [DATA_W-1:0] leaf(input logic [3:0] n);
      case (n)
         4'd7:    return DATA_W'(LEAF0);
         4'd8:    return DATA_W'(LEAF1);
         4'd9:    return DATA_W'(LEAF2);
         4'd10:   return DATA_W'(LEAF3);
         4'd11:   return DATA_W'(LEAF4);
         4'd12:   return DATA_W'(LEAF5);
         4'd13:   return DATA_W'(LEAF6);
         4'd14:   return DATA_W'(LEAF7);
         default: return '0;
      endcase
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_i) state_nxt = S_L0;
         S_L0:    state_nxt = S_L1;
         S_L1:    state_nxt = S_L2;
         S_L2:    state_nxt = S_OUT;
         S_OUT:   state_nxt = start_i ? S_L0 : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Level datapath: pick the level's latched feature, compare, step to a child (ties go right).
   always_comb begin
      case (state)
         S_L0:    feat = x1_lat;
         S_L1:    feat = x2_lat;
         default: feat = x3_lat;
      endcase
      cmp     = feat < thr(node);
      node_x2 = {node[2:0], 1'b0};
      child   = node_x2 + (cmp ? 4'd1 : 4'd2);
      load    = start_i && (state == S_IDLE || state == S_OUT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x1_lat <= '0;
         x2_lat <= '0;
         x3_lat <= '0;
         node   <= '0;
         y_lat  <= '0;
      end else if (load) begin
         x1_lat <= x1_i;
         x2_lat <= x2_i;
         x3_lat <= x3_i;
         node   <= '0;
      end else if (state == S_L0 || state == S_L1) begin
         node <= child;
      end else if (state == S_L2) begin
         node  <= child;
         y_lat <= leaf(child);
      end
   end

   always_comb begin
      y_valid_o = (state == S_OUT);
`ifdef DT_HOLD_Y_EN
      y_o = y_lat;
`else
      y_o = (state == S_OUT) ? y_lat : '0;
`endif
   end

endmodule

// File: tb/tb_decision_tree.sv
// Directed bench for decision_tree: paths, ties, back-to-back, reset abort, late input changes.
// Expected y_o between results follows DT_HOLD_Y_EN (held last result vs. zero).
module tb_decision_tree;

   logic       clock = 1'b0;
   logic       reset;
   logic       start_i;
   logic [7:0] x1_i, x2_i, x3_i;
   logic [7:0] y_o;
   logic       y_valid_o;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_y = 8'd0;

   decision_tree dut (
      .clock     (clock),
      .reset     (reset),
      .start_i   (start_i),
      .x1_i      (x1_i),
      .x2_i      (x2_i),
      .x3_i      (x3_i),
      .y_o       (y_o),
      .y_valid_o (y_valid_o)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] idle_y(input logic [7:0] last);
`ifdef DT_HOLD_Y_EN
      return last;
`else
      return 8'd0;
`endif
   endfunction

   task automatic test_reset();
      reset = 1'b1; start_i = 1'b0; x1_i = '0; x2_i = '0; x3_i = '0;
      repeat (2) @(negedge clock);
      checks++;
      if (y_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", y_valid_o); end
      checks++;
      if (y_o !== 8'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y_o); end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (y_valid_o !== 1'b0 || y_o !== 8'd0) begin
         errors++; $display("FAIL post_reset_idle: valid=%b y=%0d want 0/0", y_valid_o, y_o);
      end
      last_y = 8'd0;
   endtask

   task automatic test_single_path(input string name, input logic [7:0] a, b, c, input logic [7:0] exp);
      start_i = 1'b1; x1_i = a; x2_i = b; x3_i = c;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         start_i = 1'b0;
         checks++;
         if (y_valid_o !== 1'b0 || y_o !== idle_y(last_y)) begin
            errors++;
            $display("FAIL %s_busy%0d: valid=%b y=%0d want 0/%0d", name, i, y_valid_o, y_o, idle_y(last_y));
         end
      end
      @(negedge clock);
      checks++;
      if (y_valid_o !== 1'b1 || y_o !== exp) begin
         errors++; $display("FAIL %s_out: valid=%b y=%0d want 1/%0d", name, y_valid_o, y_o, exp);
      end
      last_y = exp;
      @(negedge clock);
      checks++;
      if (y_valid_o !== 1'b0 || y_o !== idle_y(last_y)) begin
         errors++; $display("FAIL %s_after: valid=%b y=%0d want 0/%0d", name, y_valid_o, y_o, idle_y(last_y));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] va [4] = '{8'd1, 8'd200, 8'd128, 8'd0};
      logic [7:0] vb [4] = '{8'd4, 8'd100, 8'd192, 8'd200};
      logic [7:0] vc [4] = '{8'd7, 8'd50,  8'd192, 8'd100};
      logic [7:0] ve [4] = '{8'd10, 8'd50, 8'd80,  8'd30};
      start_i = 1'b1;
      for (int v = 0; v < 4; v++) begin
         x1_i = va[v]; x2_i = vb[v]; x3_i = vc[v];
         for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (y_valid_o !== 1'b0 || y_o !== idle_y(last_y)) begin
               errors++;
               $display("FAIL b2b_busy%0d_%0d: valid=%b y=%0d want 0/%0d", v, i, y_valid_o, y_o, idle_y(last_y));
            end
         end
         @(negedge clock);
         checks++;
         if (y_valid_o !== 1'b1 || y_o !== ve[v]) begin
            errors++; $display("FAIL b2b_out%0d: valid=%b y=%0d want 1/%0d", v, y_valid_o, y_o, ve[v]);
         end
         last_y = ve[v];
      end
      start_i = 1'b0;
      @(negedge clock);
      checks++;
      if (y_valid_o !== 1'b0 || y_o !== idle_y(last_y)) begin
         errors++; $display("FAIL b2b_stop: valid=%b y=%0d want 0/%0d", y_valid_o, y_o, idle_y(last_y));
      end
   endtask

   task automatic test_reset_abort();
      start_i = 1'b1; x1_i = 8'd128; x2_i = 8'd192; x3_i = 8'd192;
      @(negedge clock);
      start_i = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      checks++;
      if (y_valid_o !== 1'b0 || y_o !== 8'd0) begin
         errors++; $display("FAIL abort_in_reset: valid=%b y=%0d want 0/0", y_valid_o, y_o);
      end
      last_y = 8'd0;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checks++;
         if (y_valid_o !== 1'b0 || y_o !== 8'd0) begin
            errors++; $display("FAIL abort_quiet%0d: valid=%b y=%0d want 0/0", i, y_valid_o, y_o);
         end
      end
      test_single_path("abort_restart", 8'd200, 8'd100, 8'd50, 8'd50);
   endtask

   task automatic test_input_change(input logic [7:0] a, b, c, input logic [7:0] exp);
      logic [7:0] junk [3] = '{8'd255, 8'd0, 8'd200};
      start_i = 1'b1; x1_i = a; x2_i = b; x3_i = c;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         start_i = (i < 2);
         x1_i = junk[i]; x2_i = junk[i]; x3_i = junk[i];
         checks++;
         if (y_valid_o !== 1'b0 || y_o !== idle_y(last_y)) begin
            errors++;
            $display("FAIL chg_busy%0d: valid=%b y=%0d want 0/%0d", i, y_valid_o, y_o, idle_y(last_y));
         end
      end
      @(negedge clock);
      checks++;
      if (y_valid_o !== 1'b1 || y_o !== exp) begin
         errors++; $display("FAIL chg_out: valid=%b y=%0d want 1/%0d", y_valid_o, y_o, exp);
      end
      last_y = exp;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checks++;
         if (y_valid_o !== 1'b0 || y_o !== idle_y(last_y)) begin
            errors++;
            $display("FAIL chg_between%0d: valid=%b y=%0d want 0/%0d", i, y_valid_o, y_o, idle_y(last_y));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_path("left_path", 8'd1, 8'd4, 8'd7, 8'd10);
      test_single_path("mixed_path", 8'd200, 8'd100, 8'd50, 8'd50);
      test_single_path("ties_right", 8'd128, 8'd192, 8'd192, 8'd80);
      test_back_to_back();
      test_reset_abort();
      test_input_change(8'd1, 8'd4, 8'd7, 8'd10);
      test_input_change(8'd200, 8'd100, 8'd50, 8'd50);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
